// File: rtl/atk_mem_pkg.sv
// Shared definitions for the SRAM boot loader: phase encodings, loader states
// and the idle level of the active-low SRAM control pins.
package atk_mem_pkg;

    localparam logic PH_COPY_IMG    = 1'b0;
    localparam logic PH_RUN_IMG     = 1'b1;
    localparam logic SRAM_CTRL_IDLE = 1'b1;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RUN
    } loader_state_e;

endpackage

// File: rtl/sram_write_strobe.sv
// One async-SRAM write: SETUP (cs low), STROBE (we low for WE_CYCLES clocks),
// HOLD (we high, bus held). Pulses done during HOLD; idle pins when not busy.
module sram_write_strobe
    import atk_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned WE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic              done,
    output logic              wr_cs_n,
    output logic              wr_we_n,
    output logic              wr_doe,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_dout
);

    localparam int unsigned CNT_W = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;

    loader_state_e     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            ST_WAIT: begin
                if (start) begin
                    state_d = ST_SETUP;
                    addr_d  = addr;
                    data_d  = data;
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
                cnt_d   = CNT_W'(WE_CYCLES - 1);
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD:  state_d = ST_WAIT;
            default:  state_d = ST_WAIT;
        endcase
    end

    // Pins decode straight from the async-reset state so reset drops WE at once.
    always_comb begin
        done    = (state_q == ST_HOLD);
        wr_cs_n = SRAM_CTRL_IDLE;
        wr_we_n = SRAM_CTRL_IDLE;
        wr_doe  = 1'b0;
        wr_addr = '0;
        wr_dout = '0;
        if (state_q == ST_SETUP || state_q == ST_STROBE || state_q == ST_HOLD) begin
            wr_cs_n = 1'b0;
            wr_we_n = (state_q == ST_STROBE) ? 1'b0 : SRAM_CTRL_IDLE;
            wr_doe  = 1'b1;
            wr_addr = addr_q;
            wr_dout = data_q;
        end
    end

endmodule

// File: rtl/sram_boot_loader.sv
// Boot loader: copies a streamed image into async SRAM while holding the CU in
// reset, then hands the SRAM bus to the CU until a reboot request.
module sram_boot_loader
    import atk_mem_pkg::*;
#(
    parameter int unsigned ADDR_W    = 18,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned CU_ADDR_W = 16,
    parameter int unsigned IMG_WORDS = 65536,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned WE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 boot_skip,
    input  logic                 reboot,
    input  logic                 src_valid,
    output logic                 src_ready,
    input  logic [DATA_W-1:0]    src_data,
    input  logic                 cu_cs_n,
    input  logic                 cu_rd_n,
    input  logic                 cu_wr_n,
    input  logic [CU_ADDR_W-1:0] cu_addr,
    input  logic [DATA_W-1:0]    cu_wdata,
    output logic [DATA_W-1:0]    cu_rdata,
    output logic                 cu_rst_n,
    output logic                 sram_cs_n,
    output logic                 sram_oe_n,
    output logic                 sram_we_n,
    output logic [ADDR_W-1:0]    sram_addr,
    output logic [DATA_W-1:0]    sram_dout,
    output logic                 sram_doe,
    input  logic [DATA_W-1:0]    sram_din,
    output logic                 phase,
    output logic [ADDR_W:0]      words_done
);

    localparam logic [ADDR_W:0]   IMG_CNT = (ADDR_W + 1)'(IMG_WORDS);
    localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);

    loader_state_e     state_q, state_d;
    logic [ADDR_W:0]   words_done_q, words_done_d;
    logic [ADDR_W:0]   words_inc;
    logic              phase_q, phase_d;
    logic              cu_rst_n_q, cu_rst_n_d;
    logic              src_ready_q, src_ready_d;
    logic              wr_start, wr_done;
    logic              wr_cs_n, wr_we_n, wr_doe;
    logic [ADDR_W-1:0] wr_addr_in, wr_addr;
    logic [DATA_W-1:0] wr_dout;

    assign wr_addr_in = BASE + words_done_q[ADDR_W-1:0];
    assign words_inc  = words_done_q + 1'b1;

    sram_write_strobe #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .WE_CYCLES (WE_CYCLES)
    ) u_strobe (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (wr_start),
        .addr    (wr_addr_in),
        .data    (src_data),
        .done    (wr_done),
        .wr_cs_n (wr_cs_n),
        .wr_we_n (wr_we_n),
        .wr_doe  (wr_doe),
        .wr_addr (wr_addr),
        .wr_dout (wr_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT;
            words_done_q <= '0;
            phase_q      <= PH_COPY_IMG;
            cu_rst_n_q   <= 1'b0;
            src_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            words_done_q <= words_done_d;
            phase_q      <= phase_d;
            cu_rst_n_q   <= cu_rst_n_d;
            src_ready_q  <= src_ready_d;
        end
    end

    // ST_SETUP here covers the whole delegated write; the strobe unit
    // sequences its own SETUP/STROBE/HOLD and reports done in HOLD.
    always_comb begin
        state_d      = state_q;
        words_done_d = words_done_q;
        wr_start     = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (words_done_q == '0 && boot_skip) begin
                    state_d = ST_RUN;
                end else if (src_valid && src_ready_q) begin
                    wr_start = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (wr_done) begin
                    words_done_d = words_inc;
                    state_d      = (words_inc == IMG_CNT) ? ST_RUN : ST_WAIT;
                end
            end
            ST_RUN: begin
                if (reboot) begin
                    state_d      = ST_WAIT;
                    words_done_d = '0;
                end
            end
            default: state_d = ST_WAIT;
        endcase
        phase_d     = (state_d == ST_RUN) ? PH_RUN_IMG : PH_COPY_IMG;
        cu_rst_n_d  = (state_d == ST_RUN);
        src_ready_d = (state_d == ST_WAIT);
    end

    always_comb begin
        if (state_q == ST_RUN) begin
            sram_cs_n = cu_cs_n;
            sram_oe_n = cu_rd_n;
            sram_we_n = cu_wr_n;
            sram_addr = ADDR_W'(cu_addr);
            sram_dout = cu_wdata;
            sram_doe  = ~cu_cs_n & ~cu_wr_n;
        end else begin
            sram_cs_n = wr_cs_n;
            sram_oe_n = SRAM_CTRL_IDLE;
            sram_we_n = wr_we_n;
            sram_addr = wr_addr;
            sram_dout = wr_dout;
            sram_doe  = wr_doe;
        end
    end

    assign cu_rdata   = sram_din;
    assign src_ready  = src_ready_q;
    assign phase      = phase_q;
    assign cu_rst_n   = cu_rst_n_q;
    assign words_done = words_done_q;

endmodule

// File: tb/tb_sram_boot_loader.sv
// Bench for sram_boot_loader: a 4-word instance (base 0x100) and a full-range
// instance (base 0x3FFFF) for the reset-abort and address-wrap cases.
module tb_sram_boot_loader;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int CW = 16;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cs_len;
        int            we_len;
        bit            stable;
    } wr_t;

    typedef struct {
        logic          cs, rd, wr;
        logic [CW-1:0] addr;
        logic [DW-1:0] wdata, din;
        logic          e_cs, e_oe, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_dout;
        logic          e_doe;
        logic [DW-1:0] e_rdata;
    } run_vec_t;

    localparam logic [37:0] IDLE_PINS = {3'b111, 18'h0, 16'h0, 1'b0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    logic          a_rst_n, a_boot_skip, a_reboot, a_src_valid, a_src_ready;
    logic [DW-1:0] a_src_data, a_cu_wdata, a_cu_rdata, a_sram_dout, a_sram_din;
    logic          a_cu_cs_n, a_cu_rd_n, a_cu_wr_n, a_cu_rst_n;
    logic [CW-1:0] a_cu_addr;
    logic          a_sram_cs_n, a_sram_oe_n, a_sram_we_n, a_sram_doe, a_phase;
    logic [AW-1:0] a_sram_addr;
    logic [AW:0]   a_words_done;

    logic          b_rst_n, b_boot_skip, b_reboot, b_src_valid, b_src_ready;
    logic [DW-1:0] b_src_data, b_cu_wdata, b_cu_rdata, b_sram_dout, b_sram_din;
    logic          b_cu_cs_n, b_cu_rd_n, b_cu_wr_n, b_cu_rst_n;
    logic [CW-1:0] b_cu_addr;
    logic          b_sram_cs_n, b_sram_oe_n, b_sram_we_n, b_sram_doe, b_phase;
    logic [AW-1:0] b_sram_addr;
    logic [AW:0]   b_words_done;

    sram_boot_loader #(
        .ADDR_W(AW), .DATA_W(DW), .CU_ADDR_W(CW),
        .IMG_WORDS(4), .BASE_ADDR(32'h100), .WE_CYCLES(2)
    ) dut_a (
        .clk(clk), .rst_n(a_rst_n), .boot_skip(a_boot_skip), .reboot(a_reboot),
        .src_valid(a_src_valid), .src_ready(a_src_ready), .src_data(a_src_data),
        .cu_cs_n(a_cu_cs_n), .cu_rd_n(a_cu_rd_n), .cu_wr_n(a_cu_wr_n),
        .cu_addr(a_cu_addr), .cu_wdata(a_cu_wdata), .cu_rdata(a_cu_rdata),
        .cu_rst_n(a_cu_rst_n), .sram_cs_n(a_sram_cs_n), .sram_oe_n(a_sram_oe_n),
        .sram_we_n(a_sram_we_n), .sram_addr(a_sram_addr), .sram_dout(a_sram_dout),
        .sram_doe(a_sram_doe), .sram_din(a_sram_din), .phase(a_phase),
        .words_done(a_words_done)
    );

    sram_boot_loader #(
        .ADDR_W(AW), .DATA_W(DW), .CU_ADDR_W(CW),
        .IMG_WORDS(32'h40000), .BASE_ADDR(32'h3FFFF), .WE_CYCLES(2)
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .boot_skip(b_boot_skip), .reboot(b_reboot),
        .src_valid(b_src_valid), .src_ready(b_src_ready), .src_data(b_src_data),
        .cu_cs_n(b_cu_cs_n), .cu_rd_n(b_cu_rd_n), .cu_wr_n(b_cu_wr_n),
        .cu_addr(b_cu_addr), .cu_wdata(b_cu_wdata), .cu_rdata(b_cu_rdata),
        .cu_rst_n(b_cu_rst_n), .sram_cs_n(b_sram_cs_n), .sram_oe_n(b_sram_oe_n),
        .sram_we_n(b_sram_we_n), .sram_addr(b_sram_addr), .sram_dout(b_sram_dout),
        .sram_doe(b_sram_doe), .sram_din(b_sram_din), .phase(b_phase),
        .words_done(b_words_done)
    );

    wr_t a_log[$];
    wr_t b_log[$];
    logic [DW-1:0] exp_mem[int];
    logic [DW-1:0] got_mem[int];
    logic [DW-1:0] img[4];
    int            gap[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [37:0] a_pins();
        return {a_sram_cs_n, a_sram_oe_n, a_sram_we_n, a_sram_addr, a_sram_dout, a_sram_doe};
    endfunction

    // Records each completed SRAM write cycle seen on the pins during COPY.
    task automatic monitor(input bit sel_b);
        bit in_cs = 0;
        wr_t cur;
        logic cs_n, we_n, oe_n, doe, ph;
        logic [AW-1:0] ad;
        logic [DW-1:0] dt;
        forever begin
            @(negedge clk);
            cs_n = sel_b ? b_sram_cs_n : a_sram_cs_n;
            we_n = sel_b ? b_sram_we_n : a_sram_we_n;
            oe_n = sel_b ? b_sram_oe_n : a_sram_oe_n;
            doe  = sel_b ? b_sram_doe  : a_sram_doe;
            ph   = sel_b ? b_phase     : a_phase;
            ad   = sel_b ? b_sram_addr : a_sram_addr;
            dt   = sel_b ? b_sram_dout : a_sram_dout;
            if (!ph && !cs_n) begin
                if (!in_cs) begin
                    in_cs = 1;
                    cur.addr = ad; cur.data = dt;
                    cur.cs_len = 0; cur.we_len = 0; cur.stable = 1;
                end
                cur.cs_len++;
                if (!we_n) cur.we_len++;
                if (ad !== cur.addr || dt !== cur.data || !doe || !oe_n) cur.stable = 0;
            end else if (in_cs) begin
                in_cs = 0;
                if (sel_b) b_log.push_back(cur); else a_log.push_back(cur);
            end
        end
    endtask

    initial fork
        monitor(1'b0);
        monitor(1'b1);
    join_none

    task automatic send_word(input bit sel_b, input logic [DW-1:0] w);
        int t = 0;
        @(negedge clk);
        if (sel_b) begin b_src_valid = 1; b_src_data = w; end
        else       begin a_src_valid = 1; a_src_data = w; end
        while (!(sel_b ? b_src_ready : a_src_ready) && t < 64) begin
            @(negedge clk);
            t++;
        end
        check(sel_b ? "b_accept_in_time" : "a_accept_in_time", 64'(t < 64), 64'd1);
        @(negedge clk);
        if (sel_b) b_src_valid = 0; else a_src_valid = 0;
    endtask

    task automatic wait_a_ready();
        int t = 0;
        while (!a_src_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        check("a_ready_in_time", 64'(a_src_ready), 64'd1);
    endtask

    // Streams img[] with gap[] idle cycles before each word and checks the
    // resulting write cycles against the address/data rules.
    task automatic do_copy(input string tag, input bit reboot_mid);
        int start = a_log.size();
        int t = 0;
        for (int i = 0; i < 4; i++) begin
            wait_a_ready();
            for (int g = 0; g < gap[i]; g++) begin
                @(negedge clk);
                check({tag, "_gap_idle"}, {26'h0, a_pins(), a_src_ready}, {26'h0, IDLE_PINS, 1'b1});
            end
            send_word(1'b0, img[i]);
            if (reboot_mid && i == 1) begin
                a_reboot = 1;
                @(negedge clk);
                a_reboot = 0;
                check({tag, "_reboot_ignored"}, {62'h0, a_phase, a_cu_rst_n}, 64'h0);
                check({tag, "_reboot_words_kept"}, 64'(a_words_done), 64'd1);
            end
        end
        while (!a_phase && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_run_in_time"}, 64'(a_phase), 64'd1);
        @(negedge clk);
        check({tag, "_run_state"}, {61'h0, a_phase, a_cu_rst_n, a_src_ready}, {61'h0, 3'b110});
        check({tag, "_words_done"}, 64'(a_words_done), 64'd4);
        check({tag, "_write_count"}, 64'(a_log.size() - start), 64'd4);
        for (int i = 0; i < 4; i++) begin
            exp_mem[32'h100 + i] = img[i];
            if (start + i < a_log.size()) begin
                check({tag, "_addr"}, 64'(a_log[start+i].addr), 64'(32'h100 + i));
                check({tag, "_data"}, 64'(a_log[start+i].data), 64'(img[i]));
                check({tag, "_cs_len"}, 64'(a_log[start+i].cs_len), 64'd4);
                check({tag, "_we_len"}, 64'(a_log[start+i].we_len), 64'd2);
                check({tag, "_stable"}, 64'(a_log[start+i].stable), 64'd1);
            end
        end
    endtask

    task automatic do_reboot(input string tag);
        @(negedge clk);
        a_reboot = 1;
        @(negedge clk);
        a_reboot = 0;
        check({tag, "_reboot_state"}, {59'h0, a_phase, a_cu_rst_n, 3'b000},
              {59'h0, 5'b00000});
        check({tag, "_reboot_words"}, 64'(a_words_done), 64'd0);
        check({tag, "_reboot_pins"}, 64'(a_pins()), 64'(IDLE_PINS));
    endtask

    task automatic apply_run(input string tag, input run_vec_t v);
        @(negedge clk);
        a_cu_cs_n = v.cs; a_cu_rd_n = v.rd; a_cu_wr_n = v.wr;
        a_cu_addr = v.addr; a_cu_wdata = v.wdata; a_sram_din = v.din;
        #1;
        check(tag, {10'h0, a_pins(), a_cu_rdata},
              {10'h0, v.e_cs, v.e_oe, v.e_we, v.e_addr, v.e_dout, v.e_doe, v.e_rdata});
    endtask

    initial begin
        run_vec_t vecs[4];
        run_vec_t rv;
        int sz;
        int t;

        a_rst_n = 0; a_boot_skip = 0; a_reboot = 0; a_src_valid = 0; a_src_data = '0;
        a_cu_cs_n = 1; a_cu_rd_n = 1; a_cu_wr_n = 1; a_cu_addr = '0; a_cu_wdata = '0;
        a_sram_din = '0;
        b_rst_n = 0; b_boot_skip = 0; b_reboot = 0; b_src_valid = 0; b_src_data = '0;
        b_cu_cs_n = 1; b_cu_rd_n = 1; b_cu_wr_n = 1; b_cu_addr = '0; b_cu_wdata = '0;
        b_sram_din = '0;

        vecs[0] = '{cs:0, rd:1, wr:0, addr:16'hBEEF, wdata:16'h1234, din:16'h0000,
                    e_cs:0, e_oe:1, e_we:0, e_addr:18'h0BEEF, e_dout:16'h1234, e_doe:1,
                    e_rdata:16'h0000};
        vecs[1] = '{cs:0, rd:0, wr:1, addr:16'h0042, wdata:16'hFFFF, din:16'h5A5A,
                    e_cs:0, e_oe:0, e_we:1, e_addr:18'h00042, e_dout:16'hFFFF, e_doe:0,
                    e_rdata:16'h5A5A};
        vecs[2] = '{cs:1, rd:1, wr:1, addr:16'hFFFF, wdata:16'h0000, din:16'hA5A5,
                    e_cs:1, e_oe:1, e_we:1, e_addr:18'h0FFFF, e_dout:16'h0000, e_doe:0,
                    e_rdata:16'hA5A5};
        vecs[3] = '{cs:1, rd:1, wr:0, addr:16'h1234, wdata:16'h5555, din:16'h0001,
                    e_cs:1, e_oe:1, e_we:0, e_addr:18'h01234, e_dout:16'h5555, e_doe:0,
                    e_rdata:16'h0001};

        repeat (3) @(negedge clk);
        check("a_reset_state",
              {a_pins(), a_src_ready, a_cu_rst_n, a_phase, a_words_done},
              {IDLE_PINS, 3'b000, 19'h0});
        check("b_reset_state",
              {b_sram_cs_n, b_sram_oe_n, b_sram_we_n, b_sram_addr, b_sram_dout, b_sram_doe,
               b_src_ready, b_cu_rst_n, b_phase, b_words_done},
              {IDLE_PINS, 3'b000, 19'h0});
        a_rst_n = 1;

        // Basic copy, no gaps
        for (int i = 0; i < 4; i++) begin img[i] = 16'hA000 + 16'(i); gap[i] = 0; end
        do_copy("basic", 1'b0);

        // Extra stream words in RUN are refused and cause no writes
        sz = a_log.size();
        a_src_valid = 1; a_src_data = 16'hDEAD;
        repeat (4) @(negedge clk);
        check("run_ready_low", 64'(a_src_ready), 64'd0);
        a_src_valid = 0;

        // RUN passthrough: fixed table then randomized vectors
        for (int i = 0; i < 4; i++) apply_run("run_table", vecs[i]);
        for (int i = 0; i < 16; i++) begin
            rv.cs = 1'($urandom); rv.rd = 1'($urandom); rv.wr = 1'($urandom);
            rv.addr = 16'($urandom); rv.wdata = 16'($urandom); rv.din = 16'($urandom);
            rv.e_cs = rv.cs; rv.e_oe = rv.rd; rv.e_we = rv.wr;
            rv.e_addr = {2'b00, rv.addr}; rv.e_dout = rv.wdata;
            rv.e_doe = (rv.cs == 0) && (rv.wr == 0); rv.e_rdata = rv.din;
            apply_run("run_random", rv);
        end
        @(negedge clk);
        a_cu_cs_n = 1; a_cu_rd_n = 1; a_cu_wr_n = 1;
        check("run_no_copy_writes", 64'(a_log.size()), 64'(sz));

        // Same image with a 5-cycle stall before word 2
        do_reboot("gaps");
        gap[2] = 5;
        do_copy("gaps", 1'b0);

        // Second image, with a reboot pulse during COPY
        do_reboot("img_b");
        for (int i = 0; i < 4; i++) begin img[i] = 16'hB000 + 16'(i); gap[i] = 0; end
        gap[1] = 2;
        do_copy("img_b", 1'b1);

        for (int r = 0; r < 3; r++) begin
            do_reboot("rand");
            for (int i = 0; i < 4; i++) begin
                img[i] = 16'($urandom);
                gap[i] = int'($urandom_range(0, 3));
            end
            do_copy("rand", r == 1);
        end

        for (int i = 0; i < a_log.size(); i++) got_mem[int'(a_log[i].addr)] = a_log[i].data;
        for (int i = 0; i < 4; i++)
            check("final_mem", 64'(got_mem.exists(32'h100 + i) ? got_mem[32'h100 + i] : 16'hXXXX),
                  64'(exp_mem[32'h100 + i]));

        // boot_skip from reset, with a word waiting on the stream
        @(negedge clk);
        a_rst_n = 0;
        #1;
        check("a_async_reset", {a_pins(), a_cu_rst_n, a_phase}, {IDLE_PINS, 2'b00});
        a_boot_skip = 1; a_src_valid = 1; a_src_data = 16'h7777;
        @(negedge clk);
        sz = a_log.size();
        a_rst_n = 1;
        repeat (2) @(negedge clk);
        check("skip_run", {61'h0, a_phase, a_cu_rst_n, a_src_ready}, {61'h0, 3'b110});
        check("skip_words", 64'(a_words_done), 64'd0);
        check("skip_no_write", 64'(a_log.size()), 64'(sz));
        a_boot_skip = 0; a_src_valid = 0;

        // Reset during STROBE, then wrap-around at the top of the address space
        @(negedge clk);
        b_rst_n = 1;
        send_word(1'b1, 16'hDEAD);
        t = 0;
        while (b_sram_we_n && t < 16) begin
            @(negedge clk);
            t++;
        end
        check("b_strobe_seen", 64'(b_sram_we_n), 64'd0);
        #1 b_rst_n = 0;
        #1;
        check("b_async_abort",
              {b_sram_cs_n, b_sram_we_n, b_sram_doe, b_sram_addr},
              {3'b110, 18'h0});
        repeat (2) @(negedge clk);
        b_log.delete();
        b_rst_n = 1;
        send_word(1'b1, 16'h1111);
        send_word(1'b1, 16'h2222);
        t = 0;
        while (!b_src_ready && t < 32) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        check("b_write_count", 64'(b_log.size()), 64'd2);
        check("b_words_done", 64'(b_words_done), 64'd2);
        if (b_log.size() == 2) begin
            check("b_first_addr", 64'(b_log[0].addr), 64'h3FFFF);
            check("b_first_data", 64'(b_log[0].data), 64'h1111);
            check("b_wrap_addr", 64'(b_log[1].addr), 64'h00000);
            check("b_wrap_data", 64'(b_log[1].data), 64'h2222);
            check("b_wrap_we_len", 64'(b_log[1].we_len), 64'd2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
